// File: rtl/seg_scan_if.sv
// Write port of the 7-segment scan controller: valid/ready handshake
// carrying four BCD digits and their decimal points.
// Ports: wr_valid (m->s), wr_ready (s->m), wr_data[15:0], wr_dp[3:0] (m->s)
interface seg_scan_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Ports: clk, rst_n (sync, active-low), en, wr (seg_scan_if.slave),
//        DIGIT[3:0] (anodes, active-low), DISPLAY[7:0] {a..g,dp}, frame_done
module seg_scan_ctrl #(
    parameter logic [15:0] PRESCALE  = 16'd50000,
    parameter int unsigned BLANK_CYC = 2,
    parameter bit          LZ_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    seg_scan_if.slave        wr,
    output logic [3:0]       DIGIT,
    output logic [7:0]       DISPLAY,
    output logic             frame_done
);

    localparam bit          HAS_GUARD  = (BLANK_CYC != 0);
    localparam logic [15:0] GUARD_LAST = 16'(BLANK_CYC) - 16'd1;
    localparam logic [15:0] SLOT_LAST  = PRESCALE - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_DRIVE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_slot;
    logic [15:0] r_cnt;
    logic [15:0] r_act_data;
    logic [3:0]  r_act_dp;
    logic [15:0] r_pend_data;
    logic [3:0]  r_pend_dp;
    logic        r_pend;

    state_t      w_state_nx;
    logic [1:0]  w_slot_nx;
    logic [15:0] w_cnt_nx;
    logic [3:0]  w_val;
    logic        w_dp;
    logic [3:0]  w_zero;
    logic [3:0]  w_blank;
    logic [7:0]  w_pat;
    logic        w_frame_end;
    logic        w_cap;
    logic        w_apply;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_slot  <= 2'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nx;
            r_slot  <= w_slot_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state; cnt spans guard and drive so a slot is PRESCALE cycles
    always_comb begin
        w_state_nx = r_state;
        w_slot_nx  = r_slot;
        w_cnt_nx   = r_cnt;
        if (!en) begin
            w_state_nx = S_IDLE;
            w_slot_nx  = 2'd0;
            w_cnt_nx   = 16'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nx = HAS_GUARD ? S_GUARD : S_DRIVE;
                    w_slot_nx  = 2'd0;
                    w_cnt_nx   = 16'd0;
                end
                S_GUARD: begin
                    w_cnt_nx = r_cnt + 16'd1;
                    if (r_cnt == GUARD_LAST) begin
                        w_state_nx = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_cnt_nx   = 16'd0;
                        w_slot_nx  = r_slot + 2'd1;
                        w_state_nx = HAS_GUARD ? S_GUARD : S_DRIVE;
                    end else begin
                        w_cnt_nx = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_slot_nx  = 2'd0;
                    w_cnt_nx   = 16'd0;
                end
            endcase
        end
    end

    // Leading-zero chain: a digit blanks only if every digit left of it is 0
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_zero[k] = (r_act_data[4*k +: 4] == 4'd0);
        end
        w_blank[3] = LZ_EN & w_zero[3];
        w_blank[2] = w_blank[3] & w_zero[2];
        w_blank[1] = w_blank[2] & w_zero[1];
        w_blank[0] = 1'b0;
    end

    assign w_val = r_act_data[{r_slot, 2'b00} +: 4];
    assign w_dp  = r_act_dp[r_slot];

    always_comb begin
        w_pat = w_blank[r_slot] ? 8'hFF : seg7(w_val);
        if (w_dp) begin
            w_pat[0] = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        DIGIT       = 4'hF;
        DISPLAY     = 8'hFF;
        w_frame_end = 1'b0;
        unique case (1'b1)
            (r_state == S_GUARD): begin
                DISPLAY = w_pat;
            end
            (r_state == S_DRIVE): begin
                DIGIT       = ~(4'b0001 << r_slot);
                DISPLAY     = w_pat;
                w_frame_end = (r_slot == 2'd3) && (r_cnt == SLOT_LAST);
            end
            default: begin
                DIGIT = 4'hF;
            end
        endcase
    end

    assign frame_done = w_frame_end;

    // Double buffer: capture needs pend=0, apply needs pend=1,
    // so the two never collide in one cycle
    assign w_cap       = wr.wr_valid & ~r_pend;
    assign w_apply     = r_pend & (w_frame_end | (r_state == S_IDLE));
    assign wr.wr_ready = ~r_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act_data  <= 16'd0;
            r_act_dp    <= 4'd0;
            r_pend_data <= 16'd0;
            r_pend_dp   <= 4'd0;
            r_pend      <= 1'b0;
        end else if (w_cap) begin
            r_pend_data <= wr.wr_data;
            r_pend_dp   <= wr.wr_dp;
            r_pend      <= 1'b1;
        end else if (w_apply) begin
            r_act_data  <= r_pend_data;
            r_act_dp    <= r_pend_dp;
            r_pend      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (PRESCALE=8, BLANK_CYC=2, LZ_EN=1).
// Expected {DIGIT,DISPLAY} per active window are queued and popped by a monitor.
module tb_seg_scan_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] DIGIT;
    logic [7:0] DISPLAY;
    logic       frame_done;

    seg_scan_if u_if ();

    seg_scan_ctrl #(
        .PRESCALE  (16'd8),
        .BLANK_CYC (2),
        .LZ_EN     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr         (u_if),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];
    logic [3:0]  prev_dig = 4'hF;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_ref(input logic [3:0] v);
        logic [7:0] t;
        case (v)
            4'd0: t = 8'h03;
            4'd1: t = 8'h9F;
            4'd2: t = 8'h25;
            4'd3: t = 8'h0D;
            4'd4: t = 8'h99;
            4'd5: t = 8'h49;
            4'd6: t = 8'h41;
            4'd7: t = 8'h1F;
            4'd8: t = 8'h01;
            4'd9: t = 8'h09;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] exp_disp(input logic [15:0] d,
                                            input logic [3:0] dp,
                                            input int k);
        logic [7:0] r;
        logic       blank;
        blank = 1'b0;
        if (k > 0) begin
            blank = 1'b1;
            for (int j = k; j < 4; j++) begin
                if (d[4*j +: 4] != 4'd0) blank = 1'b0;
            end
        end
        r = blank ? 8'hFF : seg_ref(d[4*k +: 4]);
        if (dp[k]) r[0] = 1'b0;
        return r;
    endfunction

    task automatic push_slots(input logic [15:0] d, input logic [3:0] dp,
                              input int first, input int last);
        logic [3:0] an;
        for (int k = first; k <= last; k++) begin
            an    = 4'hF;
            an[k] = 1'b0;
            exp_q.push_back({an, exp_disp(d, dp, k)});
        end
    endtask

    // Window start = anodes go from all-off to a selected digit
    always @(negedge clk) begin
        logic [11:0] e;
        if (prev_dig == 4'hF && DIGIT != 4'hF && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("window", {20'd0, DIGIT, DISPLAY}, {20'd0, e});
        end
        prev_dig <= DIGIT;
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        chk("fd_seen", {31'd0, frame_done}, 1);
    endtask

    task automatic idle_write(input logic [15:0] d, input logic [3:0] dp);
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = d;
        u_if.wr_dp    = dp;
        @(negedge clk);
        chk("cap_busy", {31'd0, u_if.wr_ready}, 0);
        u_if.wr_valid = 1'b0;
        @(negedge clk);
        chk("idle_apply", {31'd0, u_if.wr_ready}, 1);
    endtask

    initial begin
        int t;
        u_if.wr_valid = 1'b0;
        u_if.wr_data  = 16'h0;
        u_if.wr_dp    = 4'h0;

        // 1. reset and dark idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_digit", {28'd0, DIGIT}, 32'hF);
        chk("rst_disp", {24'd0, DISPLAY}, 32'hFF);
        chk("rst_ready", {31'd0, u_if.wr_ready}, 1);
        chk("rst_fd", {31'd0, frame_done}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_digit", {28'd0, DIGIT}, 32'hF);
        chk("idle_disp", {24'd0, DISPLAY}, 32'hFF);

        // 2. 1234 applied in idle, then scanned
        idle_write(16'h1234, 4'h0);
        push_slots(16'h1234, 4'h0, 0, 3);
        push_slots(16'h1234, 4'h0, 0, 3);
        en = 1'b1;
        @(negedge clk);
        chk("guard0_digit", {28'd0, DIGIT}, 32'hF);
        chk("guard0_disp", {24'd0, DISPLAY}, 32'h99);
        @(negedge clk);
        chk("guard1_digit", {28'd0, DIGIT}, 32'hF);
        @(negedge clk);
        chk("drive_digit", {28'd0, DIGIT}, 32'hE);
        wait_drain(200);
        wait_fd(100);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_done !== 1'b1 && t < 100);
        chk("fd_period", t, 32);
        @(negedge clk);
        chk("fd_pulse", {31'd0, frame_done}, 0);

        // 3. write at frame end: one more old frame, then 0050/dp3
        wait_fd(100);
        push_slots(16'h1234, 4'h0, 0, 3);
        push_slots(16'h0050, 4'b1000, 0, 3);
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = 16'h0050;
        u_if.wr_dp    = 4'b1000;
        @(negedge clk);
        u_if.wr_valid = 1'b0;
        wait_drain(200);

        // 4. write in slot 1; second offer while pending is ignored
        wait_fd(100);
        repeat (12) @(negedge clk);
        push_slots(16'h0050, 4'b1000, 2, 3);
        push_slots(16'h5678, 4'h0, 0, 3);
        push_slots(16'h5678, 4'h0, 0, 3);
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = 16'h5678;
        u_if.wr_dp    = 4'h0;
        @(negedge clk);
        chk("pend_busy", {31'd0, u_if.wr_ready}, 0);
        u_if.wr_data = 16'h9999;
        u_if.wr_dp   = 4'hF;
        repeat (3) @(negedge clk);
        u_if.wr_valid = 1'b0;
        wait_fd(100);
        chk("fd_busy", {31'd0, u_if.wr_ready}, 0);
        @(negedge clk);
        chk("fd_free", {31'd0, u_if.wr_ready}, 1);
        wait_drain(200);

        // 5. en falls mid slot 2 together with a write
        wait_fd(100);
        repeat (20) @(negedge clk);
        chk("slot2_digit", {28'd0, DIGIT}, 32'hB);
        en            = 1'b0;
        u_if.wr_valid = 1'b1;
        u_if.wr_data  = 16'h0007;
        u_if.wr_dp    = 4'b0001;
        @(negedge clk);
        chk("off_digit", {28'd0, DIGIT}, 32'hF);
        chk("off_disp", {24'd0, DISPLAY}, 32'hFF);
        chk("off_busy", {31'd0, u_if.wr_ready}, 0);
        u_if.wr_valid = 1'b0;
        @(negedge clk);
        chk("off_apply", {31'd0, u_if.wr_ready}, 1);
        push_slots(16'h0007, 4'b0001, 0, 3);
        en = 1'b1;
        @(negedge clk);
        chk("re_guard0", {28'd0, DIGIT}, 32'hF);
        chk("re_disp", {24'd0, DISPLAY}, 32'h1E);
        @(negedge clk);
        chk("re_guard1", {28'd0, DIGIT}, 32'hF);
        @(negedge clk);
        chk("re_slot0", {28'd0, DIGIT}, 32'hE);
        wait_drain(200);

        // 6. invalid BCD digit, then reset mid drive
        en = 1'b0;
        @(negedge clk);
        idle_write(16'h00A0, 4'h0);
        push_slots(16'h00A0, 4'h0, 0, 3);
        en = 1'b1;
        wait_drain(200);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_digit", {28'd0, DIGIT}, 32'hF);
        chk("mid_rst_disp", {24'd0, DISPLAY}, 32'hFF);
        chk("mid_rst_ready", {31'd0, u_if.wr_ready}, 1);
        chk("mid_rst_fd", {31'd0, frame_done}, 0);
        push_slots(16'h0000, 4'h0, 0, 3);
        rst_n = 1'b1;
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
